// File: rtl/count_seq_mon_pkg.sv
// ============================================================================
// Module   : count_seq_mon_pkg
// Purpose  : Shared types and helpers for the sequence-counter monitor.
//            Holds the monitor FSM state encoding, the counter value
//            constants and the expected-next-count function.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package count_seq_mon_pkg;

    // Monitor FSM states. The encoding is visible on mon_state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ARM    = 2'b01,
        ST_RUN    = 2'b10,
        ST_RESYNC = 2'b11
    } mon_state_t;

    // Count values produced by the observed counter
    localparam logic [1:0] C0 = 2'd0;
    localparam logic [1:0] C1 = 2'd1;
    localparam logic [1:0] C2 = 2'd2;
    localparam logic [1:0] C3 = 2'd3;

    // Count value the upstream counter must produce after (cnt, in_bit).
    // Only state 2 looks at the qualifier.
    function automatic logic [1:0] exp_next(input logic [1:0] cnt, input logic in_bit);
        logic [1:0] nxt;
        case (cnt)
            C0:      nxt = C1;
            C1:      nxt = C2;
            C2:      nxt = in_bit ? C3 : C0;
            default: nxt = C0;
        endcase
        return nxt;
    endfunction

endpackage

`default_nettype wire

// File: rtl/count_seq_mon_satcnt.sv
// ============================================================================
// Module   : count_seq_mon_satcnt
// Purpose  : Event counter with synchronous clear. Saturates at all-ones
//            when SATURATE=1, otherwise wraps to zero.
// Ports    : clk  - clock
//            rstn - synchronous active-low reset
//            inc  - count one event this cycle
//            clr  - synchronous clear, beats inc
//            cnt  - current count
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_mon_satcnt #(
    parameter int WIDTH    = 8,
    parameter bit SATURATE = 1'b1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc) begin
            if (SATURATE && (&r_cnt)) begin
                r_cnt <= r_cnt;
            end else begin
                r_cnt <= r_cnt + WIDTH'(1);
            end
        end
    end

    assign cnt = r_cnt;

endmodule

`default_nettype wire

// File: rtl/count_seq_monitor.sv
// ============================================================================
// Module   : count_seq_monitor
// Purpose  : Checker for a 2-bit sequence counter (0->1->2->{3 if in,0},
//            3->0). Flags illegal transitions, counts short (2->0) and long
//            (3->0) completed sequences and keeps a saturating error tally.
// Ports    : clk, rstn (sync, active-low), en, clr, count[1:0], in
//            seq_err, err_sticky, err_cnt[ERR_W], short_cnt[SEQ_W],
//            long_cnt[SEQ_W], mon_state[1:0]
//            err_info[4:0] = {in_q, cnt_q, count} of the first error since
//            reset/clr, present only when COUNT_SEQ_MON_CAPTURE_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_seq_monitor
    import count_seq_mon_pkg::*;
#(
    parameter int ERR_W = 8,
    parameter int SEQ_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             clr,
    input  logic [1:0]       count,
    input  logic             in,
    output logic             seq_err,
    output logic             err_sticky,
    output logic [ERR_W-1:0] err_cnt,
    output logic [SEQ_W-1:0] short_cnt,
    output logic [SEQ_W-1:0] long_cnt,
    output logic [1:0]       mon_state
`ifdef COUNT_SEQ_MON_CAPTURE_EN
    ,
    output logic [4:0]       err_info
`endif
);

    mon_state_t r_state;
    mon_state_t w_state_next;
    logic [1:0] r_cnt_q;
    logic       r_in_q;
    logic       r_seq_err;
    logic       r_sticky;

    logic [1:0] w_exp;
    logic       w_check;
    logic       w_err;
    logic       w_short;
    logic       w_long;

    // Previous sample, captured in every state so ARM/RESYNC leave a valid
    // reference for the first check in RUN.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt_q <= C0;
            r_in_q  <= 1'b0;
        end else begin
            r_cnt_q <= count;
            r_in_q  <= in;
        end
    end

    assign w_exp   = exp_next(r_cnt_q, r_in_q);
    assign w_check = (r_state == ST_RUN);
    assign w_err   = w_check && (count != w_exp);
    // A legal return to 0 closes a sequence; its length is given by cnt_q.
    assign w_short = w_check && !w_err && (r_cnt_q == C2) && (count == C0);
    assign w_long  = w_check && !w_err && (r_cnt_q == C3) && (count == C0);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Dropping en returns to IDLE from every state; in RUN the check of the
    // current sample still completes.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (en) w_state_next = ST_ARM;
            end
            ST_ARM: begin
                w_state_next = en ? ST_RUN : ST_IDLE;
            end
            ST_RUN: begin
                if (!en)       w_state_next = ST_IDLE;
                else if (w_err) w_state_next = ST_RESYNC;
            end
            default: begin
                if (!en)              w_state_next = ST_IDLE;
                else if (count == C0) w_state_next = ST_RUN;
            end
        endcase
    end

    // The error pulse fires even when clr drops the event from the counters.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_seq_err <= 1'b0;
            r_sticky  <= 1'b0;
        end else begin
            r_seq_err <= w_err;
            if (clr) begin
                r_sticky <= 1'b0;
            end else if (w_err) begin
                r_sticky <= 1'b1;
            end
        end
    end

    count_seq_mon_satcnt #(.WIDTH(ERR_W), .SATURATE(1'b1)) u_err_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (w_err),
        .clr  (clr),
        .cnt  (err_cnt)
    );

    count_seq_mon_satcnt #(.WIDTH(SEQ_W), .SATURATE(1'b0)) u_short_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (w_short),
        .clr  (clr),
        .cnt  (short_cnt)
    );

    count_seq_mon_satcnt #(.WIDTH(SEQ_W), .SATURATE(1'b0)) u_long_cnt (
        .clk  (clk),
        .rstn (rstn),
        .inc  (w_long),
        .clr  (clr),
        .cnt  (long_cnt)
    );

`ifdef COUNT_SEQ_MON_CAPTURE_EN
    logic [4:0] r_err_info;
    logic       r_info_vld;

    // Holds the first error after reset/clr. An error coinciding with clr
    // starts a fresh capture window with that error already recorded.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_err_info <= 5'd0;
            r_info_vld <= 1'b0;
        end else if (w_err && (clr || !r_info_vld)) begin
            r_err_info <= {r_in_q, r_cnt_q, count};
            r_info_vld <= 1'b1;
        end else if (clr) begin
            r_err_info <= 5'd0;
            r_info_vld <= 1'b0;
        end
    end

    assign err_info = r_err_info;
`endif

    assign seq_err    = r_seq_err;
    assign err_sticky = r_sticky;
    assign mon_state  = r_state;

endmodule

`default_nettype wire
